// File: rtl/ltl_report_collector_pkg.sv
// Shared definitions for the automaton report collector.
// Holds the default widths and the default report-entry record used by the
// collector FIFO when no other entry type is supplied.
package ltl_report_collector_pkg;

  localparam int NUM_REPORTS_DEF = 4;
  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int TS_WIDTH_DEF    = 32;
  localparam int DROP_WIDTH_DEF  = 16;

  // One queued report: symbol-cycle timestamp plus the captured report bits.
  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0]    ts;
    logic [NUM_REPORTS_DEF-1:0] vec;
  } ltl_report_t;

endpackage

// File: rtl/ltl_report_collector_if.sv
// Report drain channel between the collector and the monitor CSR/interrupt logic.
//   rpt_valid     head entry available (driven by master)
//   rpt_ready     consumer accepts head entry (driven by slave)
//   rpt_vector    head entry report bits
//   rpt_timestamp head entry timestamp
interface ltl_report_collector_if
  import ltl_report_collector_pkg::*;
#(
  parameter int NUM_REPORTS = NUM_REPORTS_DEF,
  parameter int TS_WIDTH    = TS_WIDTH_DEF
);

  logic                   rpt_valid;
  logic                   rpt_ready;
  logic [NUM_REPORTS-1:0] rpt_vector;
  logic [TS_WIDTH-1:0]    rpt_timestamp;

  modport master (output rpt_valid, output rpt_vector, output rpt_timestamp, input rpt_ready);
  modport slave  (input rpt_valid, input rpt_vector, input rpt_timestamp, output rpt_ready);

endinterface

// File: rtl/ltl_report_collector_fifo.sv
// Synchronous first-word-fall-through FIFO for report entries.
//   clk, reset  clock and synchronous active-high reset (flushes pointers)
//   push/wdata  write request; taken when not full, or when full with a pop
//   pop         remove head; ignored while empty
//   rdata       head entry (valid while !empty)
//   full/empty  status; count = current fill level
// Pointers carry one extra MSB so full and empty are distinguishable.
module ltl_report_collector_fifo
  import ltl_report_collector_pkg::*;
#(
  parameter type T     = ltl_report_t,
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  T        wdata,
  output T        rdata,
  output logic    full,
  output logic    empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  T            mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  // Status flags, accepted push/pop and the fall-through head.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    count     = wr_ptr_r - rd_ptr_r;
    do_pop_s  = pop & ~empty;
    // A pop frees the slot this same edge, so a full FIFO can still take a push.
    do_push_s = push & (~full | do_pop_s);
    rdata     = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Read/write pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ltl_report_collector.sv
// Report collector for an automaton cluster.
// Samples the report STE outputs each symbol cycle, timestamps any non-zero
// capture and queues it for draining over the rpt channel.
//   clk, reset    clock and synchronous active-high reset
//   run           symbol-valid qualifier shared with the automaton
//   reports       report STE outputs, bit i = i-th report STE
//   clear_sticky  pulse clearing violation, overflow and drop_count
//   rpt           drain channel (master side)
//   violation     sticky: any entry captured or dropped
//   overflow      sticky: any entry dropped
//   drop_count    saturating count of dropped entries
//   occupancy     FIFO fill level
module ltl_report_collector
  import ltl_report_collector_pkg::*;
#(
  parameter int NUM_REPORTS = NUM_REPORTS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int TS_WIDTH    = TS_WIDTH_DEF,
  parameter int EDGE_ONLY   = 0,
  parameter int DROP_WIDTH  = DROP_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [NUM_REPORTS-1:0]        reports,
  input  logic                          clear_sticky,
  ltl_report_collector_if.master        rpt,
  output logic                          violation,
  output logic                          overflow,
  output logic [DROP_WIDTH-1:0]         drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  typedef struct packed {
    logic [TS_WIDTH-1:0]    ts;
    logic [NUM_REPORTS-1:0] vec;
  } entry_t;

  localparam logic [TS_WIDTH-1:0]   TS_ONE   = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DROP_WIDTH-1:0] DROP_ONE = {{(DROP_WIDTH-1){1'b0}}, 1'b1};

  logic [TS_WIDTH-1:0]    ts_r;
  logic [NUM_REPORTS-1:0] prev_reports_r;
  logic [NUM_REPORTS-1:0] cap_vec_s;
  logic                   push_req_s;
  logic                   pop_s;
  logic                   drop_s;
  logic                   full_s;
  logic                   empty_s;
  entry_t                 wdata_s;
  entry_t                 head_s;
  logic                   violation_r;
  logic                   overflow_r;
  logic [DROP_WIDTH-1:0]  drop_count_r;

  // Capture vector, push/pop/drop decisions and the entry to write.
  always_comb begin
    if (EDGE_ONLY != 0) begin
      cap_vec_s = reports & ~prev_reports_r;
    end else begin
      cap_vec_s = reports;
    end
    push_req_s  = run & (|cap_vec_s);
    pop_s       = ~empty_s & rpt.rpt_ready;
    drop_s      = push_req_s & full_s & ~pop_s;
    // Stamp with the count before this cycle's increment.
    wdata_s.ts  = ts_r;
    wdata_s.vec = cap_vec_s;
  end

  ltl_report_collector_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (occupancy)
  );

  // Symbol-cycle timestamp and previous report sample, both advanced only on run.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_r           <= '0;
      prev_reports_r <= '0;
    end else if (run) begin
      ts_r           <= ts_r + TS_ONE;
      prev_reports_r <= reports;
    end
  end

  // Sticky flags and saturating drop counter; a new event outranks clear_sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      violation_r  <= 1'b0;
      overflow_r   <= 1'b0;
      drop_count_r <= '0;
    end else begin
      if (push_req_s)        violation_r <= 1'b1;
      else if (clear_sticky) violation_r <= 1'b0;

      if (drop_s)            overflow_r <= 1'b1;
      else if (clear_sticky) overflow_r <= 1'b0;

      if (clear_sticky)      drop_count_r <= drop_s ? DROP_ONE : '0;
      else if (drop_s && (drop_count_r != {DROP_WIDTH{1'b1}}))
                             drop_count_r <= drop_count_r + DROP_ONE;
    end
  end

  // Head entry presentation; fields read as zero while the queue is empty.
  always_comb begin
    rpt.rpt_valid = ~empty_s;
    if (empty_s) begin
      rpt.rpt_vector    = '0;
      rpt.rpt_timestamp = '0;
    end else begin
      rpt.rpt_vector    = head_s.vec;
      rpt.rpt_timestamp = head_s.ts;
    end
  end

  assign violation  = violation_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed bench for ltl_report_collector with a queue-based scoreboard.
// Main DUT: level capture. Second DUT: edge-only capture.
module tb_ltl_report_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  reports;
  logic        clear_sticky;
  logic        violation, overflow;
  logic [15:0] drop_count;
  logic [3:0]  occupancy;
  logic        e_violation, e_overflow;
  logic [15:0] e_drop_count;
  logic [3:0]  e_occupancy;

  int checks   = 0;
  int failures = 0;

  logic [35:0] exp_q [$];
  logic [31:0] m_ts;
  logic        m_viol, m_ovf;
  int          m_drop;

  always #5 clk = ~clk;

  ltl_report_collector_if #(.NUM_REPORTS(4), .TS_WIDTH(32)) rpt_if ();
  ltl_report_collector_if #(.NUM_REPORTS(4), .TS_WIDTH(32)) rpt_e_if ();

  ltl_report_collector #(
    .NUM_REPORTS(4), .FIFO_DEPTH(8), .TS_WIDTH(32), .EDGE_ONLY(0), .DROP_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .reports(reports), .clear_sticky(clear_sticky),
    .rpt(rpt_if), .violation(violation), .overflow(overflow),
    .drop_count(drop_count), .occupancy(occupancy)
  );

  ltl_report_collector #(
    .NUM_REPORTS(4), .FIFO_DEPTH(8), .TS_WIDTH(32), .EDGE_ONLY(1), .DROP_WIDTH(16)
  ) dut_e (
    .clk(clk), .reset(reset), .run(run), .reports(reports), .clear_sticky(1'b0),
    .rpt(rpt_e_if), .violation(e_violation), .overflow(e_overflow),
    .drop_count(e_drop_count), .occupancy(e_occupancy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: compare outputs to the model, drive inputs, advance model.
  task automatic step(input logic r, input logic [3:0] rep, input logic rdy, input logic clr);
    check("valid", rpt_if.rpt_valid, exp_q.size() != 0);
    check("occupancy", occupancy, exp_q.size());
    if (exp_q.size() != 0) begin
      check("vector", rpt_if.rpt_vector, exp_q[0][3:0]);
      check("timestamp", rpt_if.rpt_timestamp, exp_q[0][35:4]);
    end else begin
      check("vector_empty", rpt_if.rpt_vector, 0);
      check("timestamp_empty", rpt_if.rpt_timestamp, 0);
    end
    check("violation", violation, m_viol);
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drop);

    run = r; reports = rep; rpt_if.rpt_ready = rdy; clear_sticky = clr;

    if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (clr) begin m_viol = 1'b0; m_ovf = 1'b0; m_drop = 0; end
    if (r && rep != 4'd0) begin
      m_viol = 1'b1;
      if (exp_q.size() < 8) exp_q.push_back({m_ts, rep});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (r) m_ts = m_ts + 32'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; reports = 4'd0; clear_sticky = 1'b0;
    rpt_if.rpt_ready = 1'b0; rpt_e_if.rpt_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", rpt_if.rpt_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_violation", violation, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_e_occupancy", e_occupancy, 0);
    reset = 1'b0;
    exp_q.delete();
    m_ts = 32'd0; m_viol = 1'b0; m_ovf = 1'b0; m_drop = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // 1: idle run cycles leave everything empty
    for (int i = 0; i < 5; i++) step(1'b1, 4'd0, 1'b1, 1'b0);
    check("t1_valid", rpt_if.rpt_valid, 0);
    check("t1_violation", violation, 0);
    check("t1_occupancy", occupancy, 0);

    // 2: single event at ts=3, consumed one cycle after it appears
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    check("t2_valid", rpt_if.rpt_valid, 1);
    check("t2_vector", rpt_if.rpt_vector, 4'b0010);
    check("t2_ts", rpt_if.rpt_timestamp, 3);
    check("t2_violation", violation, 1);
    step(1'b1, 4'd0, 1'b1, 1'b0);
    check("t2_gone", rpt_if.rpt_valid, 0);

    // 3: ten events into an 8-deep FIFO with no consumer, then drain in order
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b0);
    check("t3_occupancy", occupancy, 8);
    check("t3_overflow", overflow, 1);
    check("t3_drop_count", drop_count, 2);
    check("t3_head_ts", rpt_if.rpt_timestamp, 5);
    for (int i = 0; i < 9; i++) step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t3_drained", occupancy, 0);

    // 4: full FIFO with simultaneous pop and push
    for (int i = 0; i < 8; i++) step(1'b1, 4'b1000, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 1'b1, 1'b0);
    check("t4_occupancy", occupancy, 8);
    check("t4_drop_count", drop_count, 2);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("t4_clr_viol", violation, 0);
    check("t4_clr_ovf", overflow, 0);
    check("t4_clr_drop", drop_count, 0);
    check("t4_clr_keeps_fifo", occupancy, 8);

    // 6: clear_sticky coincident with a drop, then reset with 3 entries queued
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    check("t6_ovf", overflow, 1);
    check("t6_drop", drop_count, 1);
    check("t6_viol", violation, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t6_three_left", occupancy, 3);
    do_reset();
    step(1'b1, 4'b1000, 1'b1, 1'b0);
    check("t6_ts_restart", rpt_if.rpt_timestamp, 0);
    check("t6_valid", rpt_if.rpt_valid, 1);
    step(1'b0, 4'd0, 1'b1, 1'b0);

    // 5: edge-only capture: 0001 held 4 cycles then 0011
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 4'b0011, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t5_e_occupancy", e_occupancy, 2);
    check("t5_e_vec0", rpt_e_if.rpt_vector, 4'b0001);
    check("t5_e_ts0", rpt_e_if.rpt_timestamp, 0);
    rpt_e_if.rpt_ready = 1'b1;
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t5_e_vec1", rpt_e_if.rpt_vector, 4'b0010);
    check("t5_e_ts1", rpt_e_if.rpt_timestamp, 4);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("t5_e_empty", rpt_e_if.rpt_valid, 0);
    check("t5_e_viol", e_violation, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
